s9io_axil_arbiter: RTL and testbench
====================================

S9IO_AXIL_ARBITER -- requirements
Module: s9io_axil_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, the AXI4-Lite byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the register data width; only 32 is supported.
REQ-003 ACLK  input  1  single clock; all logic rising-edge.
REQ-004 ARESETN  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  2  per-requester transaction request.
REQ-006 req_ready  output  2  one-cycle grant/accept pulse per requester.
REQ-007 req_write  input  2  1=write, 0=read, per requester.
REQ-008 req_addr  input  2*ADDR_WIDTH  byte address; requester n uses slice n.
REQ-009 req_wdata  input  64  write data; requester n uses bits [32n+31:32n].
REQ-010 rsp_valid  output  2  one-cycle completion pulse per requester.
REQ-011 rsp_rdata  output  64  read data, slice per requester.
REQ-012 rsp_resp  output  4  AXI response code, 2 bits per requester.
REQ-013 M_AXI_AWADDR/AWVALID/AWREADY  output/output/input  ADDR_WIDTH/1/1  write address channel.
REQ-014 M_AXI_WDATA/WSTRB/WVALID/WREADY  output/output/output/input  32/4/1/1  write data channel.
REQ-015 M_AXI_BRESP/BVALID/BREADY  input/input/output  2/1/1  write response channel.
REQ-016 M_AXI_ARADDR/ARVALID/ARREADY  output/output/input  ADDR_WIDTH/1/1  read address channel.
REQ-017 M_AXI_RDATA/RRESP/RVALID/RREADY  input/input/input/output  32/2/1/1  read data channel.

Function
REQ-018 FSM states: IDLE, WR (AW+W pending), WB (await B), RA (await AR), RD (await R); one outstanding transaction maximum.
REQ-019 In IDLE with any req_valid set, grant one requester: if both valid, the one not granted last (round-robin); if one valid, that one.
REQ-020 Grant cycle: req_ready[g]=1 for exactly that cycle; addr, wdata, write captured; next state WR if write, else RA.
REQ-021 Requesters hold req_valid and fields until req_ready; the arbiter never drops a pending request.
REQ-022 AWADDR/ARADDR = captured address with bits [1:0] forced 0; WSTRB = 4'hF.
REQ-023 WR: AWVALID and WVALID both assert the cycle after grant; each deasserts independently after its own handshake; move to WB once both have completed, in any order or simultaneously.
REQ-024 WB: BREADY=1; on BVALID, next cycle rsp_valid[g]=1, rsp_resp[g]=BRESP, rsp_rdata[g]=0, state IDLE.
REQ-025 RA: ARVALID=1 until ARREADY; then RD with RREADY=1; on RVALID, next cycle rsp_valid[g]=1, rsp_rdata[g]=RDATA, rsp_resp[g]=RRESP, state IDLE.
REQ-026 A new grant is permitted in the same cycle rsp_valid pulses; with an always-ready slave, accept-to-rsp_valid is 3 cycles and back-to-back throughput is one transaction per 3 cycles.
REQ-027 rsp_rdata/rsp_resp slices hold their last values until the next response to that requester.
REQ-028 SLVERR/DECERR responses are forwarded unchanged; no retry.

Reset
REQ-029 With ARESETN=0 at a clock edge: state IDLE; all VALID/READY outputs, req_ready, rsp_valid 0; all data/addr/resp outputs 0; last-grant = requester 1, so requester 0 wins the first tie.
REQ-030 Reset during any state abandons the transaction with no rsp_valid; outputs reach reset values at that edge.

Verification
REQ-031 Write 0x00000001 to addr 0x0 via requester 0, slave always ready -> AW/W one cycle, rsp_valid[0] 3 cycles after req_ready[0], rsp_resp[1:0]=0.
REQ-032 Both requesters valid from reset (req 0 read 0x4, req 1 write 0x8 = 0xA5A5A5A5) -> grant order 0,1,0,1; no double grant.
REQ-033 Slave delays WREADY 3 cycles after AWREADY -> AWVALID drops after 1 cycle, WVALID holds 4 cycles, single BREADY handshake.
REQ-034 Writes 1..4 to 0x0/0x4/0x8/0xC, then reads back -> rsp_rdata matches 1,2,3,4; addr 0x5 issues ARADDR 0x4.
REQ-035 ARESETN low while in RD with RVALID stalled -> no rsp_valid, RREADY 0 on the reset edge, next request serviced normally.
REQ-036 Slave returns BRESP=2'b10 -> rsp_resp slice = 2'b10, FSM returns to IDLE.

Source files
------------

// File: rtl/s9io_axil_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI4-Lite master port.
// One transaction outstanding at a time; a new grant may overlap the completing response.
//
// state | meaning
// IDLE  | no transaction in flight, waiting for a request
// WR    | write granted; AW and W issued, waiting for both handshakes
// WB    | write address/data done, waiting for B
// RA    | read granted; AR issued, waiting for ARREADY
// RD    | read address done, waiting for R
module s9io_axil_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_rdata,
    output logic [3:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD} state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                state;
    logic                  launch;
    logic                  cur;
    logic                  last_grant;
    logic                  grant_idx;
    logic                  grant_ok;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] aligned_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign M_AXI_WSTRB = '1;

    always_comb begin
        grant_idx    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        sel_addr     = grant_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        sel_wdata    = grant_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        aligned_addr = sel_addr & ALIGN_MASK;
        // A grant may overlap the cycle in which the previous response completes.
        grant_ok     = (|req_valid) &&
                       ((state == IDLE) ||
                        (state == WB && M_AXI_BVALID) ||
                        (state == RD && M_AXI_RVALID));
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= IDLE;
            launch        <= 1'b0;
            cur           <= 1'b0;
            last_grant    <= 1'b1;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: ;
                WR: begin
                    if (launch) begin
                        launch        <= 1'b0;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                    end else begin
                        if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                        if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
                        if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                            state        <= WB;
                            M_AXI_BREADY <= 1'b1;
                        end
                    end
                end
                WB: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY                                  <= 1'b0;
                        rsp_valid[cur]                                <= 1'b1;
                        rsp_resp[int'(cur)*2 +: 2]                    <= M_AXI_BRESP;
                        rsp_rdata[int'(cur)*DATA_WIDTH +: DATA_WIDTH] <= '0;
                        state                                         <= IDLE;
                    end
                end
                RA: begin
                    if (launch) begin
                        launch        <= 1'b0;
                        M_AXI_ARVALID <= 1'b1;
                    end else if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD;
                    end
                end
                RD: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY                                  <= 1'b0;
                        rsp_valid[cur]                                <= 1'b1;
                        rsp_resp[int'(cur)*2 +: 2]                    <= M_AXI_RRESP;
                        rsp_rdata[int'(cur)*DATA_WIDTH +: DATA_WIDTH] <= M_AXI_RDATA;
                        state                                         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (grant_ok) begin
                req_ready[grant_idx] <= 1'b1;
                cur                  <= grant_idx;
                last_grant           <= grant_idx;
                launch               <= 1'b1;
                if (req_write[grant_idx]) begin
                    M_AXI_AWADDR <= aligned_addr;
                    M_AXI_WDATA  <= sel_wdata;
                    state        <= WR;
                end else begin
                    M_AXI_ARADDR <= aligned_addr;
                    state        <= RA;
                end
            end
        end
    end

endmodule

// File: tb/tb_s9io_axil_arbiter.sv
// Directed bench for s9io_axil_arbiter with a small AXI4-Lite slave model
// (configurable ready delays, response codes and read stall).
module tb_s9io_axil_arbiter;

    logic        ACLK;
    logic        ARESETN;
    logic [1:0]  req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [63:0] rsp_rdata;
    logic [3:0]  rsp_resp;
    logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic        M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    int n_checks = 0;
    int n_fail   = 0;

    s9io_axil_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Cycle counter and bus activity monitor.
    int          cyc = 0;
    int          aw_cyc = 0, w_cyc = 0, b_hs_cnt = 0, dbl_cnt = 0, rsp_cnt = 0;
    logic [3:0]  last_araddr = '0;

    always @(posedge ACLK) cyc <= cyc + 1;

    always @(negedge ACLK) begin
        aw_cyc   <= aw_cyc + int'(M_AXI_AWVALID);
        w_cyc    <= w_cyc + int'(M_AXI_WVALID);
        b_hs_cnt <= b_hs_cnt + int'(M_AXI_BVALID && M_AXI_BREADY);
        dbl_cnt  <= dbl_cnt + int'(req_ready == 2'b11);
        rsp_cnt  <= rsp_cnt + int'(rsp_valid[0]) + int'(rsp_valid[1]);
        if (M_AXI_ARVALID) last_araddr <= M_AXI_ARADDR;
    end

    // Slave model: samples handshakes at negedge, drives its outputs 1 time unit after posedge.
    int          aw_delay = 0, w_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit          r_stall = 1'b0;
    logic [31:0] mem [4];

    initial begin
        bit          aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_seen, w_seen;
        logic [3:0]  s_awaddr, s_araddr, wr_addr;
        logic [31:0] s_wdata, wr_data;
        int          aw_cnt, w_cnt;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        aw_seen = 0; w_seen = 0; aw_cnt = 0; w_cnt = 0;
        wr_addr = '0; wr_data = '0;
        forever begin
            @(negedge ACLK);
            aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
            w_hs  = M_AXI_WVALID && M_AXI_WREADY;
            b_hs  = M_AXI_BVALID && M_AXI_BREADY;
            ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
            r_hs  = M_AXI_RVALID && M_AXI_RREADY;
            s_awaddr = M_AXI_AWADDR; s_araddr = M_AXI_ARADDR; s_wdata = M_AXI_WDATA;
            @(posedge ACLK);
            #1;
            if (!ARESETN) begin
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
                M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
                aw_seen = 0; w_seen = 0; aw_cnt = 0; w_cnt = 0;
            end else begin
                if (aw_hs) begin aw_seen = 1; wr_addr = s_awaddr; end
                if (w_hs)  begin w_seen = 1;  wr_data = s_wdata;  end
                if (b_hs) M_AXI_BVALID = 0;
                if (aw_seen && w_seen) begin
                    mem[wr_addr[3:2]] = wr_data;
                    M_AXI_BVALID = 1; M_AXI_BRESP = bresp_cfg;
                    aw_seen = 0; w_seen = 0;
                end
                if (r_hs) M_AXI_RVALID = 0;
                if (ar_hs && !r_stall) begin
                    M_AXI_RVALID = 1; M_AXI_RDATA = mem[s_araddr[3:2]]; M_AXI_RRESP = rresp_cfg;
                end
                if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_cnt >= aw_delay); aw_cnt++; end
                else begin M_AXI_AWREADY = 0; aw_cnt = 0; end
                if (M_AXI_WVALID) begin M_AXI_WREADY = (w_cnt >= w_delay); w_cnt++; end
                else begin M_AXI_WREADY = 0; w_cnt = 0; end
                M_AXI_ARREADY = M_AXI_ARVALID;
            end
        end
    end

    // Stimulus helper: one request from requester idx, bounded waits; ok=0 on timeout.
    task automatic run_txn(input int idx, input bit wr, input logic [3:0] addr, input logic [31:0] wd,
                           output int t_rdy, output int t_rsp, output logic [31:0] rd,
                           output logic [1:0] rs, output bit ok);
        bit got;
        ok = 0; t_rdy = 0; t_rsp = 0; rd = '0; rs = '0;
        @(negedge ACLK);
        req_write[idx] = wr;
        req_addr[4*idx +: 4] = addr;
        req_wdata[32*idx +: 32] = wd;
        req_valid[idx] = 1'b1;
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge ACLK);
            if (req_ready[idx]) begin got = 1; t_rdy = cyc; end
        end
        req_valid[idx] = 1'b0;
        if (!got) return;
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge ACLK);
            if (rsp_valid[idx]) begin
                got = 1; t_rsp = cyc;
                rd = rsp_rdata[32*idx +: 32];
                rs = rsp_resp[2*idx +: 2];
            end
        end
        ok = got;
    endtask

    task automatic test_reset;
        req_valid = 2'b11; req_write = 2'b11; req_addr = 8'h84; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) @(negedge ACLK);
        n_checks++;
        if ({req_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0",
                     {req_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
        end
        n_checks++;
        if ({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h expected 0", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA});
        end
        n_checks++;
        if ({rsp_rdata, rsp_resp} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: got %h expected 0", {rsp_rdata, rsp_resp});
        end
        n_checks++;
        if (M_AXI_WSTRB !== 4'hF) begin
            n_fail++;
            $display("FAIL wstrb: got %h expected f", M_AXI_WSTRB);
        end
        req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
        ARESETN = 1'b1;
    endtask

    task automatic test_round_robin;
        int order [4];
        int gcyc [4];
        int n_g = 0;
        int d0;
        @(posedge ACLK);
        d0 = dbl_cnt;
        @(negedge ACLK);
        req_write = 2'b10; req_addr = 8'h84; req_wdata = {32'hA5A5_A5A5, 32'h0};
        req_valid = 2'b11;
        for (int n = 0; n < 60 && n_g < 4; n++) begin
            @(negedge ACLK);
            if (req_ready == 2'b01 || req_ready == 2'b10) begin
                order[n_g] = int'(req_ready[1]); gcyc[n_g] = cyc; n_g++;
                if (n_g == 4) req_valid = 2'b00;
            end
        end
        req_valid = 2'b00;
        repeat (8) @(negedge ACLK);
        @(posedge ACLK);
        n_checks++;
        if (n_g != 4) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d expected 4", n_g);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (order[i] != (i % 2)) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], i % 2);
                end
            end
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (gcyc[i] - gcyc[i-1] != 3) begin
                    n_fail++;
                    $display("FAIL rr_spacing[%0d]: got %0d expected 3", i, gcyc[i] - gcyc[i-1]);
                end
            end
        end
        n_checks++;
        if (dbl_cnt - d0 != 0) begin
            n_fail++;
            $display("FAIL rr_double_grant: got %0d expected 0", dbl_cnt - d0);
        end
    endtask

    task automatic test_single_write;
        int a0, w0, b0, tr, ts;
        logic [31:0] rd;
        logic [1:0] rs;
        bit ok;
        @(posedge ACLK);
        a0 = aw_cyc; w0 = w_cyc; b0 = b_hs_cnt;
        run_txn(0, 1'b1, 4'h0, 32'h0000_0001, tr, ts, rd, rs, ok);
        repeat (2) @(posedge ACLK);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL sw_timeout: got timeout expected completion"); end
        n_checks++;
        if (ts - tr != 3) begin n_fail++; $display("FAIL sw_latency: got %0d expected 3", ts - tr); end
        n_checks++;
        if (rs !== 2'b00 || rd !== 32'h0) begin
            n_fail++; $display("FAIL sw_rsp: got resp %b rdata %h expected 00/0", rs, rd);
        end
        n_checks++;
        if (aw_cyc - a0 != 1 || w_cyc - w0 != 1 || b_hs_cnt - b0 != 1) begin
            n_fail++;
            $display("FAIL sw_channels: got aw %0d w %0d b %0d expected 1/1/1", aw_cyc - a0, w_cyc - w0, b_hs_cnt - b0);
        end
    endtask

    task automatic test_wready_delay;
        int a0, w0, b0, tr, ts;
        logic [31:0] rd;
        logic [1:0] rs;
        bit ok;
        w_delay = 3;
        @(posedge ACLK);
        a0 = aw_cyc; w0 = w_cyc; b0 = b_hs_cnt;
        run_txn(1, 1'b1, 4'hC, 32'h1234_5678, tr, ts, rd, rs, ok);
        repeat (2) @(posedge ACLK);
        w_delay = 0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wd_timeout: got timeout expected completion"); end
        n_checks++;
        if (aw_cyc - a0 != 1) begin n_fail++; $display("FAIL wd_awvalid_cycles: got %0d expected 1", aw_cyc - a0); end
        n_checks++;
        if (w_cyc - w0 != 4) begin n_fail++; $display("FAIL wd_wvalid_cycles: got %0d expected 4", w_cyc - w0); end
        n_checks++;
        if (b_hs_cnt - b0 != 1) begin n_fail++; $display("FAIL wd_b_handshakes: got %0d expected 1", b_hs_cnt - b0); end
        n_checks++;
        if (ts - tr != 6) begin n_fail++; $display("FAIL wd_latency: got %0d expected 6", ts - tr); end
    endtask

    task automatic test_readback;
        int tr, ts;
        logic [31:0] rd;
        logic [1:0] rs;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            run_txn(0, 1'b1, 4'(4*i), 32'(i+1), tr, ts, rd, rs, ok);
            n_checks++;
            if (!ok || rs !== 2'b00) begin
                n_fail++; $display("FAIL rb_write[%0d]: got ok %0d resp %b expected 1/00", i, ok, rs);
            end
        end
        for (int i = 0; i < 4; i++) begin
            run_txn(1, 1'b0, 4'(4*i), 32'h0, tr, ts, rd, rs, ok);
            n_checks++;
            if (!ok || rd !== 32'(i+1) || ts - tr != 3) begin
                n_fail++;
                $display("FAIL rb_read[%0d]: got ok %0d rdata %h lat %0d expected 1/%h/3", i, ok, rd, ts - tr, 32'(i+1));
            end
        end
        n_checks++;
        if (rsp_rdata[31:0] !== 32'h0) begin
            n_fail++; $display("FAIL rb_hold_req0: got %h expected 0", rsp_rdata[31:0]);
        end
        run_txn(1, 1'b0, 4'h5, 32'h0, tr, ts, rd, rs, ok);
        @(posedge ACLK);
        n_checks++;
        if (last_araddr !== 4'h4) begin n_fail++; $display("FAIL rb_araddr_align: got %h expected 4", last_araddr); end
        n_checks++;
        if (!ok || rd !== 32'h2) begin n_fail++; $display("FAIL rb_unaligned_read: got %h expected 2", rd); end
        run_txn(0, 1'b1, 4'hC, 32'h4, tr, ts, rd, rs, ok);
        n_checks++;
        if (rsp_rdata[63:32] !== 32'h2) begin
            n_fail++; $display("FAIL rb_hold_req1: got %h expected 2", rsp_rdata[63:32]);
        end
    endtask

    task automatic test_reset_in_rd;
        int r0, tr, ts;
        logic [31:0] rd;
        logic [1:0] rs;
        bit ok, got;
        r_stall = 1'b1;
        @(posedge ACLK);
        r0 = rsp_cnt;
        @(negedge ACLK);
        req_write[0] = 1'b0; req_addr[3:0] = 4'h0; req_valid[0] = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge ACLK);
            if (req_ready[0]) got = 1;
        end
        req_valid[0] = 1'b0;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge ACLK);
            if (M_AXI_RREADY) got = 1;
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL rr_reach_rd: got timeout expected RREADY"); end
        ARESETN = 1'b0;
        @(negedge ACLK);
        n_checks++;
        if ({M_AXI_RREADY, M_AXI_ARVALID, rsp_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_rd_outputs: got %b expected 0", {M_AXI_RREADY, M_AXI_ARVALID, rsp_valid});
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        r_stall = 1'b0;
        repeat (4) @(negedge ACLK);
        @(posedge ACLK);
        n_checks++;
        if (rsp_cnt - r0 != 0) begin n_fail++; $display("FAIL rst_rd_no_rsp: got %0d expected 0", rsp_cnt - r0); end
        run_txn(0, 1'b0, 4'h8, 32'h0, tr, ts, rd, rs, ok);
        n_checks++;
        if (!ok || rd !== 32'h3 || rs !== 2'b00 || ts - tr != 3) begin
            n_fail++;
            $display("FAIL rst_rd_recover: got ok %0d rdata %h resp %b lat %0d expected 1/3/00/3", ok, rd, rs, ts - tr);
        end
    endtask

    task automatic test_error_resp;
        int tr, ts;
        logic [31:0] rd;
        logic [1:0] rs;
        bit ok;
        bresp_cfg = 2'b10;
        run_txn(1, 1'b1, 4'h0, 32'h9, tr, ts, rd, rs, ok);
        bresp_cfg = 2'b00;
        n_checks++;
        if (!ok || rs !== 2'b10) begin n_fail++; $display("FAIL slverr_bresp: got %b expected 10", rs); end
        rresp_cfg = 2'b11;
        run_txn(0, 1'b0, 4'h0, 32'h0, tr, ts, rd, rs, ok);
        rresp_cfg = 2'b00;
        n_checks++;
        if (!ok || rs !== 2'b11 || rd !== 32'h9) begin
            n_fail++; $display("FAIL decerr_rresp: got resp %b rdata %h expected 11/9", rs, rd);
        end
        n_checks++;
        if (rsp_resp[3:2] !== 2'b10) begin n_fail++; $display("FAIL err_resp_hold: got %b expected 10", rsp_resp[3:2]); end
        run_txn(1, 1'b0, 4'h4, 32'h0, tr, ts, rd, rs, ok);
        n_checks++;
        if (!ok || rs !== 2'b00 || rd !== 32'h2 || ts - tr != 3) begin
            n_fail++;
            $display("FAIL err_recover: got ok %0d resp %b rdata %h lat %0d expected 1/00/2/3", ok, rs, rd, ts - tr);
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_round_robin();
        test_single_write();
        test_wready_delay();
        test_readback();
        test_reset_in_rd();
        test_error_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
